tcbm_byte_receiver: RTL and testbench

//  TCBM bus slave front-end for the Plus/4-to-SD bridge. Performs the host->drive 4-phase DAV/ACK

---
 rtl/tcbm_byte_receiver.sv | 154 +++++++++++++++
 tb/tb_tcbm_byte_receiver.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcbm_byte_receiver.sv
// tcbm_byte_receiver: TCBM host->drive receiver, command byte then data byte over a 4-phase DAV/ACK handshake.
// Latency: pin edges are seen SYNC_STAGES cycles late and the FSM reacts one cycle after that; all outputs are registered.
// Backpressure: the data-byte ACK is withheld until downstream takes out_data. Define TCBM_TIMEOUT_EN to enable the watchdog (status 2'b11).
module tcbm_byte_receiver #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cs_n,
   input  logic       dav_n,
   input  logic [7:0] data_in,
   output logic       ack_n,
   output logic [7:0] cmd,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] st_d,
   output logic       st_en
);

   typedef enum logic [2:0] {IDLE, CMD_ACK, DATA_WAIT, DATA_HOLD, DATA_ACK} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] dav_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   dav_hi;   // synchronized dav_n (1 = strobe inactive)
   logic                   cs_hi;    // synchronized cs_n (1 = not selected)
   logic                   abort;
   logic                   advance;
   logic                   tmo_hit;
   logic                   cmd_ok;

   // Synchronizers preset to the inactive level so reset never looks like a strobe
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dav_sync <= '1;
         cs_sync  <= '1;
      end else begin
         dav_sync <= {dav_sync[SYNC_STAGES-2:0], dav_n};
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      end
   end

   assign dav_hi = dav_sync[SYNC_STAGES-1];
   assign cs_hi  = cs_sync[SYNC_STAGES-1];
   assign cmd_ok = (cmd >= 8'h81) && (cmd <= 8'h84);

   // Deselect wins over every other event in any busy state
   assign abort = cs_hi && (state != IDLE);

   // The one handshake event each state is waiting for
   always_comb begin
      advance = 1'b0;
      case (state)
         IDLE:      advance = !cs_hi && !dav_hi;
         CMD_ACK:   advance = dav_hi;
         DATA_WAIT: advance = !dav_hi;
         DATA_HOLD: advance = out_valid && out_ready;
         DATA_ACK:  advance = dav_hi;
         default:   advance = 1'b0;
      endcase
   end

`ifdef TCBM_TIMEOUT_EN
   localparam int            CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] tmo_cnt;
   logic          counting;

   // DATA_HOLD is excluded: a slow downstream is not the host's fault
   assign counting = (state == CMD_ACK) || (state == DATA_WAIT) || (state == DATA_ACK);
   assign tmo_hit  = counting && (tmo_cnt == TMO_MAX);

   // Watchdog: cleared on every state change, saturating count while waiting on the host
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         tmo_cnt <= '0;
      else if (abort || advance || tmo_hit)
         tmo_cnt <= '0;
      else if (counting && (tmo_cnt != TMO_MAX))
         tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Handshake FSM with registered ack/data/status outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ack_n     <= 1'b1;
         cmd       <= 8'h00;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         st_d      <= 2'b00;
         st_en     <= 1'b0;
      end else begin
         st_en <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            ack_n     <= 1'b1;
            out_valid <= 1'b0;
         end else if (advance) begin
            case (state)
               IDLE: begin
                  cmd   <= data_in;
                  ack_n <= 1'b0;
                  state <= CMD_ACK;
               end
               CMD_ACK: begin
                  ack_n <= 1'b1;
                  if (cmd_ok) begin
                     state <= DATA_WAIT;
                  end else begin
                     st_d  <= 2'b10;
                     st_en <= 1'b1;
                     state <= IDLE;
                  end
               end
               DATA_WAIT: begin
                  out_data  <= data_in;
                  out_valid <= 1'b1;
                  state     <= DATA_HOLD;
               end
               DATA_HOLD: begin
                  out_valid <= 1'b0;
                  ack_n     <= 1'b0;
                  state     <= DATA_ACK;
               end
               DATA_ACK: begin
                  ack_n <= 1'b1;
                  st_d  <= 2'b00;
                  st_en <= 1'b1;
                  state <= IDLE;
               end
               default: begin
                  ack_n     <= 1'b1;
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            endcase
         end else if (tmo_hit) begin
            ack_n     <= 1'b1;
            out_valid <= 1'b0;
            st_d      <= 2'b11;
            st_en     <= 1'b1;
            state     <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_tcbm_byte_receiver.sv
// Directed bench for tcbm_byte_receiver: host handshakes, bad commands, backpressure, deselect, reset, watchdog.
// Expected values are hand-derived from the handshake protocol.
// A posedge monitor counts st_en pulses, ack_n falls and downstream transfers.
module tb_tcbm_byte_receiver;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       cs_n  = 1'b1;
   logic       dav_n = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       ack_n;
   logic [7:0] cmd;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [1:0] st_d;
   logic       st_en;

   int total = 0;
   int bad   = 0;

   int         sten_cnt  = 0;
   int         hs_cnt    = 0;
   int         afall_cnt = 0;
   int         vrise_cnt = 0;
   logic [1:0] last_st   = 2'b00;
   logic [7:0] last_out  = 8'h00;
   logic       ack_prev  = 1'b1;
   logic       vld_prev  = 1'b0;

   tcbm_byte_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset(reset), .cs_n(cs_n), .dav_n(dav_n), .data_in(data_in),
      .ack_n(ack_n), .cmd(cmd), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .st_d(st_d), .st_en(st_en)
   );

   always #5 clock = ~clock;

   // Event monitor: values read here are the registered outputs before this edge updates them
   always @(posedge clock) begin
      ack_prev <= ack_n;
      vld_prev <= out_valid;
      if (ack_prev && !ack_n) afall_cnt <= afall_cnt + 1;
      if (!vld_prev && out_valid) vrise_cnt <= vrise_cnt + 1;
      if (st_en) begin
         sten_cnt <= sten_cnt + 1;
         last_st  <= st_d;
      end
      if (out_valid && out_ready) begin
         hs_cnt   <= hs_cnt + 1;
         last_out <= out_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_ack(input logic v, input string tag);
      int n = 0;
      while (ack_n !== v && n < 60) begin
         @(negedge clock);
         n++;
      end
      chk(tag, {31'd0, ack_n}, {31'd0, v});
   endtask

   task automatic wait_vld(input string tag);
      int n = 0;
      while (out_valid !== 1'b1 && n < 60) begin
         @(negedge clock);
         n++;
      end
      chk(tag, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic host_cmd(input logic [7:0] c);
      data_in = c;
      dav_n   = 1'b0;
      wait_ack(1'b0, "cmd_ack_low");
      dav_n = 1'b1;
      wait_ack(1'b1, "cmd_ack_high");
   endtask

   task automatic host_data(input logic [7:0] d);
      data_in = d;
      dav_n   = 1'b0;
      wait_ack(1'b0, "data_ack_low");
      dav_n = 1'b1;
      wait_ack(1'b1, "data_ack_high");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int s, h, a, v, badcyc, n;
      logic [7:0] badcmds [2];
      badcmds[0] = 8'h90;
      badcmds[1] = 8'h85;

      // Reset state
      cyc(3);
      chk("rst_ack_n", {31'd0, ack_n}, 32'd1);
      chk("rst_cmd", {24'd0, cmd}, 32'h00);
      chk("rst_out_data", {24'd0, out_data}, 32'h00);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_st_d", {30'd0, st_d}, 32'd0);
      chk("rst_st_en", {31'd0, st_en}, 32'd0);
      reset = 1'b0;
      cs_n  = 1'b0;
      cyc(4);

      // 1: command 0x81 then data 0x5A, downstream always ready
      s = sten_cnt; h = hs_cnt; a = afall_cnt;
      out_ready = 1'b1;
      host_cmd(8'h81);
      chk("t1_cmd", {24'd0, cmd}, 32'h81);
      host_data(8'h5A);
      cyc(2);
      chk("t1_out_data", {24'd0, last_out}, 32'h5A);
      chk("t1_handshakes", hs_cnt - h, 32'd1);
      chk("t1_ack_falls", afall_cnt - a, 32'd2);
      chk("t1_st_en_count", sten_cnt - s, 32'd1);
      chk("t1_st_d", {30'd0, last_st}, 32'd0);

      // 3: data 0x33 held by downstream for 20 cycles, ack withheld meanwhile
      out_ready = 1'b0;
      s = sten_cnt; h = hs_cnt;
      host_cmd(8'h82);
      data_in = 8'h33;
      dav_n   = 1'b0;
      wait_vld("t3_valid_rise");
      badcyc = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (!(ack_n === 1'b1 && out_valid === 1'b1 && out_data === 8'h33)) badcyc++;
      end
      chk("t3_hold_bad_cycles", badcyc, 32'd0);
      chk("t3_out_data", {24'd0, out_data}, 32'h33);
      out_ready = 1'b1;
      cyc(1);
      chk("t3_ack_after_ready", {31'd0, ack_n}, 32'd0);
      chk("t3_valid_after_ready", {31'd0, out_valid}, 32'd0);
      dav_n = 1'b1;
      wait_ack(1'b1, "t3_ack_release");
      cyc(2);
      chk("t3_handshakes", hs_cnt - h, 32'd1);
      chk("t3_st_en_count", sten_cnt - s, 32'd1);
      chk("t3_st_d", {30'd0, last_st}, 32'd0);

      // 4: deselect while the byte is held downstream
      out_ready = 1'b0;
      s = sten_cnt;
      host_cmd(8'h83);
      data_in = 8'h44;
      dav_n   = 1'b0;
      wait_vld("t4_valid_rise");
      cyc(2);
      cs_n = 1'b1;
      cyc(2);
      chk("t4_valid_before_sync", {31'd0, out_valid}, 32'd1);
      cyc(1);
      chk("t4_valid_dropped", {31'd0, out_valid}, 32'd0);
      chk("t4_ack_n", {31'd0, ack_n}, 32'd1);
      cyc(3);
      chk("t4_no_st_en", sten_cnt - s, 32'd0);
      dav_n = 1'b1;
      cs_n  = 1'b0;
      cyc(5);
      out_ready = 1'b1;
      host_cmd(8'h81);
      host_data(8'hC3);
      cyc(2);
      chk("t4_next_out_data", {24'd0, last_out}, 32'hC3);
      chk("t4_next_st_en", sten_cnt - s, 32'd1);
      chk("t4_next_st_d", {30'd0, last_st}, 32'd0);

      // 2: bad commands (0x90, and 0x85 just above the legal range)
      for (int k = 0; k < 2; k++) begin
         s = sten_cnt; v = vrise_cnt;
         data_in = badcmds[k];
         dav_n   = 1'b0;
         wait_ack(1'b0, "t2_ack_low");
         cyc(5);
         chk("t2_ack_held", {31'd0, ack_n}, 32'd0);
         chk("t2_no_early_st_en", sten_cnt - s, 32'd0);
         dav_n = 1'b1;
         wait_ack(1'b1, "t2_ack_release");
         cyc(2);
         chk("t2_st_en_count", sten_cnt - s, 32'd1);
         chk("t2_st_d", {30'd0, st_d}, 32'd2);
         chk("t2_no_valid", vrise_cnt - v, 32'd0);
      end

      // 5: asynchronous reset while in DATA_ACK
      s = sten_cnt;
      host_cmd(8'h82);
      data_in = 8'h77;
      dav_n   = 1'b0;
      wait_ack(1'b0, "t5_data_ack_low");
      chk("t5_st_d_before", {30'd0, st_d}, 32'd2);
      #3;
      reset = 1'b1;
      #1;
      chk("t5_ack_n", {31'd0, ack_n}, 32'd1);
      chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_st_d", {30'd0, st_d}, 32'd0);
      chk("t5_cmd", {24'd0, cmd}, 32'h00);
      dav_n = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(4);
      chk("t5_no_st_en", sten_cnt - s, 32'd0);

      // 6: host stalls in DATA_WAIT
      s = sten_cnt;
      host_cmd(8'h84);
`ifdef TCBM_TIMEOUT_EN
      n = 0;
      while (st_en !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      chk("t6_tmo_st_en", {31'd0, st_en}, 32'd1);
      chk("t6_tmo_st_d", {30'd0, st_d}, 32'd3);
      chk("t6_tmo_not_early", {31'd0, n >= 12}, 32'd1);
      chk("t6_tmo_ack_n", {31'd0, ack_n}, 32'd1);
      chk("t6_tmo_out_valid", {31'd0, out_valid}, 32'd0);
      dav_n = 1'b1;
      cyc(3);
      h = hs_cnt;
      host_cmd(8'h81);
      host_data(8'hE1);
      cyc(2);
      chk("t6_after_tmo_out", {24'd0, last_out}, 32'hE1);
      chk("t6_after_tmo_hs", hs_cnt - h, 32'd1);
`else
      n = 0;
      badcyc = 0;
      for (int i = 0; i < 1000; i++) begin
         cyc(1);
         if (!(ack_n === 1'b1 && out_valid === 1'b0 && st_en === 1'b0)) badcyc++;
      end
      chk("t6_wait_bad_cycles", badcyc, 32'd0);
      chk("t6_no_st_en", sten_cnt - s, 32'd0);
      host_data(8'hE1);
      cyc(2);
      chk("t6_late_out_data", {24'd0, last_out}, 32'hE1);
      chk("t6_late_st_en", sten_cnt - s, 32'd1);
      chk("t6_late_st_d", {30'd0, last_st}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
